// File: rtl/cpu_clk_seq.sv
// -----------------------------------------------------------------------------
// cpu_clk_seq
//
// Machine-cycle sequencer for the CPU model's clock resource. From the
// free-running system clock it produces a one-clk clock-enable pulse (ce) at a
// programmable divided rate and a one-hot T-state beat ring (T1..T4). A
// machine cycle is four ce ticks. The sequencer can run continuously, step a
// single machine cycle, or halt at the next machine-cycle boundary.
//
// Ports:
//   clk         in   system clock, all state changes on the rising edge
//   reset       in   asynchronous, active-low reset
//   div_ratio   in   ce period minus one, in clk cycles (0 = ce every clk)
//   run         in   level, request continuous running
//   step        in   single machine-cycle request (rising edge detected here)
//   halt        in   level, stop at next machine-cycle boundary, blocks starts
//   ce          out  registered one-clk pulse marking each T-state advance
//   t_state     out  registered one-hot beat: 0001=T1 .. 1000=T4
//   busy        out  registered, 1 while in RUN or STEP
//   mcycle_cnt  out  completed machine cycles, wraps to 0
//   dbg_state   out  current FSM state encoding (0=IDLE, 1=RUN, 2=STEP)
//
// Handshake: there is no valid/ready pairing here; run and halt are levels
// sampled on every clk, step is an edge request that is only honoured in
// IDLE (edges arriving while active are dropped, not queued).
// -----------------------------------------------------------------------------
module cpu_clk_seq #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    output logic             ce,
    output logic [3:0]       t_state,
    output logic             busy,
    output logic [CNT_W-1:0] mcycle_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   prescaler_q, prescaler_d;
    logic [DIV_W-1:0]   div_lat_q, div_lat_d;
    logic               step_q;
    logic               ce_q, ce_d;
    logic [3:0]         t_state_q, t_state_d;
    logic [CNT_W-1:0]   mcycle_cnt_q, mcycle_cnt_d;

    logic               step_rise;
    logic               tick;

    assign step_rise = step & ~step_q;
    // The divide ratio is latched so that a change mid machine cycle cannot
    // stretch or shorten the beats already in progress.
    assign tick      = (prescaler_q == div_lat_q);

    always_comb begin
        state_d      = state_q;
        prescaler_d  = prescaler_q;
        div_lat_d    = div_lat_q;
        ce_d         = 1'b0;
        t_state_d    = t_state_q;
        mcycle_cnt_d = mcycle_cnt_q;

        case (state_q)
            S_IDLE: begin
                prescaler_d = '0;
                t_state_d   = 4'b0001;
                // halt blocks any start; run wins over a simultaneous step.
                if (!halt) begin
                    if (run) begin
                        state_d   = S_RUN;
                        div_lat_d = div_ratio;
                    end else if (step_rise) begin
                        state_d   = S_STEP;
                        div_lat_d = div_ratio;
                    end
                end
            end

            S_RUN, S_STEP: begin
                if (tick) begin
                    prescaler_d = '0;
                    ce_d        = 1'b1;
                    t_state_d   = {t_state_q[2:0], t_state_q[3]};
                    // Tick out of T4 closes the machine cycle: the only point
                    // where the ratio is reloaded and stop/continue is decided.
                    if (t_state_q[3]) begin
                        mcycle_cnt_d = mcycle_cnt_q + CNT_W'(1);
                        div_lat_d    = div_ratio;
                        if (!((state_q == S_RUN) && run && !halt)) begin
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    prescaler_d = prescaler_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            prescaler_q  <= '0;
            div_lat_q    <= '0;
            step_q       <= 1'b0;
            ce_q         <= 1'b0;
            t_state_q    <= 4'b0001;
            mcycle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            prescaler_q  <= prescaler_d;
            div_lat_q    <= div_lat_d;
            step_q       <= step;
            ce_q         <= ce_d;
            t_state_q    <= t_state_d;
            mcycle_cnt_q <= mcycle_cnt_d;
        end
    end

    assign ce         = ce_q;
    assign t_state    = t_state_q;
    assign busy       = (state_q != S_IDLE);
    assign mcycle_cnt = mcycle_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_clk_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_clk_seq
//
// Bench for cpu_clk_seq (built with CNT_W=4 so counter wrap is reachable).
// Inputs change on the falling edge; outputs are compared on the falling edge
// against a behavioural model that counts beats and machine cycles with plain
// integers. A table of hand-derived vectors covers continuous run, and
// directed sequences cover step, halt, ratio change, wrap and async reset.
// -----------------------------------------------------------------------------
module tb_cpu_clk_seq;
  localparam int DIV_W = 8;
  localparam int CNT_W = 4;
  localparam int OUT_W = 1 + 4 + 1 + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [DIV_W-1:0] div_ratio;
  logic             run;
  logic             step;
  logic             halt;
  logic             ce;
  logic [3:0]       t_state;
  logic             busy;
  logic [CNT_W-1:0] mcycle_cnt;
  logic [1:0]       dbg_state;

  cpu_clk_seq #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .div_ratio  (div_ratio),
    .run        (run),
    .step       (step),
    .halt       (halt),
    .ce         (ce),
    .t_state    (t_state),
    .busy       (busy),
    .mcycle_cnt (mcycle_cnt),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 continuous, 2 single machine cycle
  int m_mode, m_pre, m_lat, m_beat, m_cnt;
  bit m_ce, m_step_prev;

  logic [OUT_W-1:0] exp_q[$];

  function automatic void model_reset();
    m_mode = 0; m_pre = 0; m_lat = 0; m_beat = 0; m_cnt = 0;
    m_ce = 1'b0; m_step_prev = 1'b0;
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    logic [3:0] beat_oh;
    beat_oh = 4'(1 << m_beat);
    return {m_ce, beat_oh, (m_mode != 0), CNT_W'(m_cnt)};
  endfunction

  function automatic void model_clock();
    bit rise;
    if (!reset) begin
      model_reset();
    end else begin
      rise = step && !m_step_prev;
      m_step_prev = step;
      if (m_mode == 0) begin
        m_ce = 1'b0; m_pre = 0; m_beat = 0;
        if (!halt && run) begin
          m_mode = 1; m_lat = int'(div_ratio);
        end else if (!halt && rise) begin
          m_mode = 2; m_lat = int'(div_ratio);
        end
      end else if (m_pre == m_lat) begin
        m_pre = 0; m_ce = 1'b1;
        if (m_beat == 3) begin
          m_beat = 0;
          m_cnt  = (m_cnt + 1) % (1 << CNT_W);
          m_lat  = int'(div_ratio);
          if (!(m_mode == 1 && run && !halt)) m_mode = 0;
        end else begin
          m_beat = m_beat + 1;
        end
      end else begin
        m_pre = m_pre + 1; m_ce = 1'b0;
      end
    end
    exp_q.push_back(model_out());
  endfunction

  // ---------------- checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_sb();
    logic [OUT_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL sb_empty: got no expected entry expected one at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("sb_outputs", 32'({ce, t_state, busy, mcycle_cnt}), 32'(e));
    end
  endtask

  // one clock: model evaluates at the edge, outputs compared at the falling edge
  task automatic cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    chk_sb();
  endtask

  task automatic drive_idle();
    run = 1'b0; step = 1'b0; halt = 1'b0; div_ratio = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    model_reset();
    exp_q.delete();
    repeat (2) cycle();
    reset = 1'b1;
  endtask

  // wait (bounded) for a ce pulse with the given beat; returns found flag
  task automatic wait_beat(input logic [3:0] beat, input string name);
    int k;
    k = 0;
    while (!(ce && t_state == beat) && k < 40) begin
      cycle();
      k++;
    end
    chk({name, "_reached"}, 32'(ce && t_state == beat), 32'd1);
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic       run;
    logic       step;
    logic       halt;
    logic [7:0] div;
    logic       ce;
    logic [3:0] t;
    logic       busy;
    logic [3:0] cnt;
  } vec_t;

  vec_t vt[14];

  initial begin
    int n, ce_n, gap_ok, max_cnt;
    int ce_times[$];

    reset = 1'b0;
    drive_idle();
    model_reset();

    // run 1 for 9 clks at ratio 0, then released: finishes the cycle in flight
    vt[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0001, 1'b1, 4'd0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0010, 1'b1, 4'd0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0100, 1'b1, 4'd0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'b1000, 1'b1, 4'd0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0001, 1'b1, 4'd1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0010, 1'b1, 4'd1};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0100, 1'b1, 4'd1};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'b1000, 1'b1, 4'd1};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0001, 1'b1, 4'd2};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0010, 1'b1, 4'd2};
    vt[10] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0100, 1'b1, 4'd2};
    vt[11] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 4'b1000, 1'b1, 4'd2};
    vt[12] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 4'b0001, 1'b0, 4'd3};
    vt[13] = '{1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'b0001, 1'b0, 4'd3};

    // ---- reset held with inputs toggling ----
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1)); div_ratio = DIV_W'($urandom_range(0, 3));
      cycle();
      chk("rst_held", 32'({ce, t_state, busy, mcycle_cnt}), 32'({1'b0, 4'b0001, 1'b0, 4'd0}));
    end
    drive_idle();
    reset = 1'b1;
    repeat (3) cycle();
    chk("rst_release_idle", 32'({busy, ce, t_state}), 32'({1'b0, 1'b0, 4'b0001}));

    // ---- table: continuous run at ratio 0 ----
    for (int i = 0; i < 14; i++) begin
      run = vt[i].run; step = vt[i].step; halt = vt[i].halt; div_ratio = vt[i].div;
      cycle();
      chk($sformatf("vec%0d", i), 32'({ce, t_state, busy, mcycle_cnt}),
          32'({vt[i].ce, vt[i].t, vt[i].busy, vt[i].cnt}));
    end

    // ---- single step at ratio 2, second step edge mid-cycle dropped ----
    do_reset();
    div_ratio = 8'd2;
    step = 1'b1;
    cycle();
    step = 1'b0;
    ce_n = 0;
    ce_times.delete();
    for (int k = 0; k < 30; k++) begin
      if (k == 5) step = 1'b1;
      if (k == 6) step = 1'b0;
      cycle();
      if (ce) begin ce_n++; ce_times.push_back(k); end
    end
    chk("step_ce_count", 32'(ce_n), 32'd4);
    gap_ok = 1;
    for (int j = 1; j < ce_times.size(); j++)
      if (ce_times[j] - ce_times[j-1] != 3) gap_ok = 0;
    chk("step_ce_spacing", 32'(gap_ok), 32'd1);
    chk("step_end", 32'({t_state, busy, mcycle_cnt}), 32'({4'b0001, 1'b0, 4'd1}));

    // ---- halt at T2, ratio 1 ----
    do_reset();
    div_ratio = 8'd1;
    run = 1'b1;
    wait_beat(4'b0010, "halt_t2");
    halt = 1'b1;
    ce_n = 0;
    n = 0;
    do begin
      cycle();
      n++;
      if (ce) ce_n++;
    end while (busy && n < 20);
    chk("halt_finish_ce", 32'(ce_n), 32'd3);
    chk("halt_idle", 32'({busy, t_state}), 32'({1'b0, 4'b0001}));
    n = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (busy || ce) n++;
    end
    chk("halt_holds_idle", 32'(n), 32'd0);
    halt = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!ce && n < 20);
    // entry edge plus two clks until the first tick
    chk("halt_resume_latency", 32'(n), 32'd3);

    // ---- ratio change 1 -> 4 during T2 ----
    do_reset();
    div_ratio = 8'd1;
    run = 1'b1;
    wait_beat(4'b0010, "ratio_t2");
    div_ratio = 8'd4;
    ce_times.delete();
    ce_times.push_back(0);
    n = 0;
    while (ce_times.size() < 6 && n < 60) begin
      cycle();
      n++;
      if (ce) ce_times.push_back(n);
    end
    chk("ratio_pulses", 32'(ce_times.size()), 32'd6);
    if (ce_times.size() == 6) begin
      chk("ratio_gap_t3", 32'(ce_times[1] - ce_times[0]), 32'd2);
      chk("ratio_gap_t4", 32'(ce_times[2] - ce_times[1]), 32'd2);
      chk("ratio_gap_t1", 32'(ce_times[3] - ce_times[2]), 32'd2);
      chk("ratio_gap_next", 32'(ce_times[4] - ce_times[3]), 32'd5);
      chk("ratio_gap_next2", 32'(ce_times[5] - ce_times[4]), 32'd5);
    end

    // ---- counter wrap, ratio 0, 16 machine cycles ----
    do_reset();
    div_ratio = 8'd0;
    run = 1'b1;
    cycle();
    max_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      cycle();
      if (int'(mcycle_cnt) > max_cnt) max_cnt = int'(mcycle_cnt);
    end
    chk("wrap_max", 32'(max_cnt), 32'd15);
    chk("wrap_zero", 32'({mcycle_cnt, t_state, busy}), 32'({4'd0, 4'b0001, 1'b1}));

    // ---- async reset between edges during T3 ----
    div_ratio = 8'd1;
    n = 0;
    while (!(mcycle_cnt != 0 && t_state == 4'b0100) && n < 40) begin
      cycle();
      n++;
    end
    chk("async_t3_reached", 32'(t_state == 4'b0100 && mcycle_cnt != 0), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_clear", 32'({ce, t_state, busy, mcycle_cnt}), 32'({1'b0, 4'b0001, 1'b0, 4'd0}));
    model_reset();
    exp_q.delete();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    repeat (2) cycle();
    chk("async_release_idle", 32'({busy, ce}), 32'd0);

    // ---- randomized run/step/halt/ratio against the model ----
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      run   = ($urandom_range(0, 2) == 0);
      step  = 1'($urandom_range(0, 1));
      halt  = ($urandom_range(0, 7) == 0);
      if ((i % 8) == 0) div_ratio = DIV_W'($urandom_range(0, 3));
      cycle();
    end
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
